// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants, IF/ID record type and jump-target helper for the MIPS pipeline
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  // j/jal destination: region bits come from the delay-slot PC, not the jump's own PC
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [31:0] instr);
    return {pc_plus4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with reset > flush > stall > load priority
module if_id_reg
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output if_id_t      if_id_o
);

  if_id_t if_id_q, if_id_d;

  // A flushed slot still records where it came from so the PC fields stay meaningful
  always_comb begin
    if_id_d = if_id_q;
    if (flush_i) begin
      if_id_d.pc       = pc_i;
      if_id_d.pc_plus4 = pc_i + 32'd4;
      if_id_d.instr    = NOP_WORD;
      if_id_d.valid    = 1'b0;
    end else if (!stall_i) begin
      if_id_d.pc       = pc_i;
      if_id_d.pc_plus4 = pc_i + 32'd4;
      if_id_d.instr    = instr_i;
      if_id_d.valid    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      if_id_q.pc       <= 32'd0;
      if_id_q.pc_plus4 <= 32'd0;
      if_id_q.instr    <= NOP_WORD;
      if_id_q.valid    <= 1'b0;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign if_id_o = if_id_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - MIPS IF stage: PC, IF/ID capture, retired-fetch counter, idle-loop halt
module instruction_fetch_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] ImemAddress,
  input  logic [31:0] ImemInstruction,
  output logic [31:0] IfIdPC,
  output logic [31:0] IfIdPCPlus4,
  output logic [31:0] IfIdInstruction,
  output logic        IfIdValid,
  output logic [31:0] FetchCount,
  output logic        Halted
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic        halted_q, halted_d;
  logic        fetch_load;
  logic        halt_hit;
  if_id_t      if_id;

  // Redirect outranks stall so a branch held in IF/ID can still steer the PC
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (Redirect) begin
      pc_d = {RedirectTarget[31:2], 2'b00};
    end else if (Stall) begin
      pc_d = pc_q;
    end
  end

  if_id_reg u_if_id_reg (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (Flush),
    .stall_i (Stall),
    .pc_i    (pc_q),
    .instr_i (ImemInstruction),
    .if_id_o (if_id)
  );

  assign fetch_load = !Flush && !Stall;
  assign halt_hit   = if_id.valid && (if_id.instr[31:26] == OP_J) &&
                      (jump_target(if_id.pc_plus4, if_id.instr) == if_id.pc);

  always_comb begin
    count_d  = count_q;
    halted_d = halted_q | halt_hit;
    if (fetch_load && !halted_q) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      count_q  <= 32'd0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  assign ImemAddress     = pc_q;
  assign IfIdPC          = if_id.pc;
  assign IfIdPCPlus4     = if_id.pc_plus4;
  assign IfIdInstruction = if_id.instr;
  assign IfIdValid       = if_id.valid;
  assign FetchCount      = count_q;
  assign Halted          = halted_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - scoreboard bench for instruction_fetch_stage with a behavioural fetch model
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, Stall, Flush, Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] ImemAddress, ImemInstruction;
  logic [31:0] IfIdPC, IfIdPCPlus4, IfIdInstruction, FetchCount;
  logic        IfIdValid, Halted;

  always #5 clk = ~clk;

  instruction_fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .Stall           (Stall),
    .Flush           (Flush),
    .Redirect        (Redirect),
    .RedirectTarget  (RedirectTarget),
    .ImemAddress     (ImemAddress),
    .ImemInstruction (ImemInstruction),
    .IfIdPC          (IfIdPC),
    .IfIdPCPlus4     (IfIdPCPlus4),
    .IfIdInstruction (IfIdInstruction),
    .IfIdValid       (IfIdValid),
    .FetchCount      (FetchCount),
    .Halted          (Halted)
  );

  // Program words from the test program; everything else is a scrambled filler word
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0040_0000: return 32'h241a_0001;
      32'h0040_0004: return 32'h8c08_0000;
      32'h0040_0008: return 32'h2004_0004;
      32'h0040_0030: return 32'h2001_000c;
      32'h0040_01A0: return 32'h0810_0068;
      default:       return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endcase
  endfunction

  assign ImemInstruction = imem_word(ImemAddress);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] cnt;
    logic        halted;
  } snap_t;

  snap_t m;
  snap_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of the fetch stage as a transaction: what the world looks like after the edge
  function automatic void model_step(input logic r, s, f, rd, input logic [31:0] t);
    snap_t n;
    logic  idle_loop;
    if (r) begin
      n = '{pc: 32'h0040_0000, ipc: 32'd0, ipc4: 32'd0, instr: 32'd0, valid: 1'b0, cnt: 32'd0, halted: 1'b0};
    end else begin
      n = m;
      idle_loop = m.valid && (m.instr[31:26] == 6'h02) &&
                  ({m.ipc4[31:28], m.instr[25:0], 2'b00} == m.ipc);
      n.halted = m.halted || idle_loop;
      if (f) begin
        n.ipc = m.pc; n.ipc4 = m.pc + 32'd4; n.instr = 32'd0; n.valid = 1'b0;
      end else if (!s) begin
        n.ipc = m.pc; n.ipc4 = m.pc + 32'd4; n.instr = imem_word(m.pc); n.valid = 1'b1;
        if (!m.halted) n.cnt = m.cnt + 32'd1;
      end
      if (rd)      n.pc = t & 32'hFFFF_FFFC;
      else if (!s) n.pc = m.pc + 32'd4;
    end
    m = n;
  endfunction

  task automatic cyc(input logic r, s, f, rd, input logic [31:0] t);
    @(negedge clk);
    reset = r; Stall = s; Flush = f; Redirect = rd; RedirectTarget = t;
    model_step(r, s, f, rd, t);
    exp_q.push_back(m);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    snap_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_ImemAddress",     ImemAddress,             e.pc);
      chk("sb_IfIdPC",          IfIdPC,                  e.ipc);
      chk("sb_IfIdPCPlus4",     IfIdPCPlus4,             e.ipc4);
      chk("sb_IfIdInstruction", IfIdInstruction,         e.instr);
      chk("sb_IfIdValid",       {31'd0, IfIdValid},      {31'd0, e.valid});
      chk("sb_FetchCount",      FetchCount,              e.cnt);
      chk("sb_Halted",          {31'd0, Halted},         {31'd0, e.halted});
    end
  end

  initial begin
    logic        r, s, f, rd;
    logic [31:0] t;
    logic [31:0] frozen;
    m = '0;
    reset = 1'b1; Stall = 1'b0; Flush = 1'b0; Redirect = 1'b0; RedirectTarget = 32'd0;

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    settle();
    chk("rst_imem_addr", ImemAddress, 32'h0040_0000);
    chk("rst_valid", {31'd0, IfIdValid}, 32'd0);
    cyc(0, 0, 0, 0, 0);
    settle();
    chk("first_pc", IfIdPC, 32'h0040_0000);
    chk("first_instr", IfIdInstruction, 32'h241a_0001);
    cyc(0, 0, 0, 0, 0);
    settle();
    chk("second_pc", IfIdPC, 32'h0040_0004);
    chk("second_instr", IfIdInstruction, 32'h8c08_0000);
    chk("second_count", FetchCount, 32'd2);

    repeat (3) cyc(0, 1, 0, 0, 0);
    settle();
    chk("stall_pc", ImemAddress, 32'h0040_0008);
    chk("stall_ifid", IfIdPC, 32'h0040_0004);
    cyc(0, 0, 0, 0, 0);
    settle();
    chk("unstall_instr", IfIdInstruction, 32'h2004_0004);
    chk("unstall_count", FetchCount, 32'd3);

    cyc(0, 0, 1, 1, 32'h0040_0030);
    settle();
    chk("jal_bubble", {31'd0, IfIdValid}, 32'd0);
    chk("jal_pc", ImemAddress, 32'h0040_0030);
    cyc(0, 0, 0, 0, 0);
    settle();
    chk("jal_target_pc", IfIdPC, 32'h0040_0030);
    chk("jal_target_instr", IfIdInstruction, 32'h2001_000c);

    cyc(0, 0, 0, 1, 32'h0040_0033);
    settle();
    chk("misaligned", ImemAddress, 32'h0040_0030);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 32'h0040_0100);
    settle();
    chk("redir_stall_pc", ImemAddress, 32'h0040_0100);
    chk("redir_stall_ifid", IfIdPC, 32'h0040_0030);

    cyc(0, 0, 1, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0);
    settle();
    chk("wrap_pc", ImemAddress, 32'h0000_0000);
    chk("wrap_plus4", IfIdPCPlus4, 32'h0000_0000);

    cyc(0, 0, 1, 1, 32'h0040_01A0);
    cyc(0, 0, 0, 0, 0);
    settle();
    chk("halt_not_yet", {31'd0, Halted}, 32'd0);
    cyc(0, 0, 0, 0, 0);
    frozen = m.cnt;
    settle();
    chk("halt_set", {31'd0, Halted}, 32'd1);
    repeat (3) cyc(0, 0, 0, 0, 0);
    settle();
    chk("halt_count_frozen", FetchCount, frozen);
    chk("halt_sticky", {31'd0, Halted}, 32'd1);
    cyc(1, 1, 0, 1, 32'h0040_0100);
    settle();
    chk("halt_reset", {31'd0, Halted}, 32'd0);
    chk("reset_dominates", ImemAddress, 32'h0040_0000);

    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 99) < 3);
      s  = ($urandom_range(0, 99) < 25);
      f  = ($urandom_range(0, 99) < 20);
      rd = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 7) == 0) t = 32'h0040_01A0;
      else t = 32'h0040_0000 + (32'($urandom_range(0, 255)) << 2) + 32'($urandom_range(0, 3));
      cyc(r, s, f, rd, t);
    end
    cyc(0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
